ram_trace_packetizer: RTL and testbench

//  Parametrised successor to the single-packet DS RAM write tracer. Captures PSRAM bus events
//  (address latch, write, optional read), queues them as 32-bit packets in a FIFO, and streams

---
 rtl/ram_trace_packetizer.sv | 186 ++++++++++++++++++
 tb/tb_ram_trace_packetizer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_trace_packetizer.sv
// PSRAM bus event tracer: captures address/write (and optionally read) events as 32-bit packets
// and streams them MSB-first to the FX2 slave FIFO. Optional read capture: define TRACE_READS_EN.
module ram_trace_packetizer #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 16,
  parameter int FIFO_AW      = 4,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               ev_strobe,
  input  logic               ram_write_sync,
  input  logic               ram_addr_sync,
  input  logic               ram_read_sync,
  input  logic [ADDR_W-1:0]  ram_a_sync,
  input  logic [DATA_W-1:0]  ram_d_sync,
  input  logic               usb_full,
  output logic [7:0]         usb_d,
  output logic               usb_slwr_n,
  output logic               usb_pktend_n,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        drop_count,
  output logic               overflow_pulse
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(FLUSH_CYCLES);
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [TW-1:0]      TIMER_LAST = TW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0]      TIMER_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_FLUSH
  } state_t;

  state_t               state;
  logic [31:0]          mem [0:DEPTH-1];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW:0]     count;
  logic [23:0]          shreg;
  logic [1:0]           idx;
  logic                 dirty;
  logic [TW-1:0]        timer;

  logic                 ev_valid;
  logic [31:0]          ev_pkt;
  logic                 pop;
  logic                 full_eff;
  logic                 marker_req;
  logic                 push;
  logic [31:0]          push_data;

  always_comb begin
    ev_valid = 1'b0;
    ev_pkt   = '0;
    if (ev_strobe) begin
      if (ram_write_sync) begin
        ev_valid = 1'b1;
        ev_pkt   = {2'b01, 30'(ram_d_sync)};
      end else if (ram_addr_sync) begin
        ev_valid = 1'b1;
        ev_pkt   = {2'b00, 30'(ram_a_sync)};
      end
`ifdef TRACE_READS_EN
      else if (ram_read_sync) begin
        ev_valid = 1'b1;
        ev_pkt   = {2'b10, 30'(ram_a_sync)};
      end
`endif
    end
  end

`ifndef TRACE_READS_EN
  logic unused_read;
  assign unused_read = ram_read_sync;
`endif

  // A pop in LOAD frees a slot in the same cycle, so a full FIFO can still accept a push.
  // The drop marker owns the single write port whenever it is pending and there is room.
  assign pop        = (state == S_LOAD);
  assign full_eff   = (count == CNT_FULL) && !pop;
  assign marker_req = (drop_count != 16'd0) && !full_eff;
  assign push       = marker_req || (ev_valid && !full_eff);
  assign push_data  = marker_req ? {2'b11, 14'd0, drop_count} : ev_pkt;
  assign fifo_level = count;

  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      drop_count     <= 16'd0;
      overflow_pulse <= 1'b0;
    end else begin
      overflow_pulse <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (marker_req) begin
        drop_count     <= ev_valid ? 16'd1 : 16'd0;
        overflow_pulse <= ev_valid;
      end else if (ev_valid && full_eff) begin
        overflow_pulse <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Host handshake: usb_slwr_n pulses low for one cycle, only after a SETUP cycle that saw
  // usb_full low; usb_d is held from SETUP through STROBE so the FX2 latches a stable byte.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      shreg        <= '0;
      idx          <= 2'd0;
      usb_d        <= 8'h00;
      usb_slwr_n   <= 1'b1;
      usb_pktend_n <= 1'b1;
      dirty        <= 1'b0;
      timer        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_LOAD;
          end else if (dirty) begin
            if (timer == TIMER_LAST) begin
              state        <= S_FLUSH;
              usb_pktend_n <= 1'b0;
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end
        end
        S_LOAD: begin
          shreg <= mem[rd_ptr][23:0];
          usb_d <= mem[rd_ptr][31:24];
          idx   <= 2'd3;
          timer <= '0;
          state <= S_SETUP;
        end
        S_SETUP: begin
          if (!usb_full) begin
            usb_slwr_n <= 1'b0;
            state      <= S_STROBE;
          end
        end
        S_STROBE: begin
          usb_slwr_n <= 1'b1;
          dirty      <= 1'b1;
          if (idx == 2'd0) begin
            state <= S_IDLE;
          end else begin
            idx   <= idx - 2'd1;
            usb_d <= shreg[23:16];
            shreg <= {shreg[15:0], 8'h00};
            state <= S_SETUP;
          end
        end
        S_FLUSH: begin
          usb_pktend_n <= 1'b1;
          dirty        <= 1'b0;
          timer        <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_trace_packetizer.sv
// Directed bench for ram_trace_packetizer: byte stream, back-pressure, drops/markers, flush, reset.
module tb_ram_trace_packetizer;

  localparam int F = 64;

  logic        mclk = 1'b0;
  logic        reset;
  logic        ev_strobe;
  logic        ram_write_sync;
  logic        ram_addr_sync;
  logic        ram_read_sync;
  logic [22:0] ram_a_sync;
  logic [15:0] ram_d_sync;
  logic        usb_full;
  logic [7:0]  usb_d;
  logic        usb_slwr_n;
  logic        usb_pktend_n;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;
  logic        overflow_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int pktend_cnt = 0;
  int last_wr_cyc = 0;
  int last_pkt_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  ram_trace_packetizer #(
    .ADDR_W(23), .DATA_W(16), .FIFO_AW(4), .FLUSH_CYCLES(F)
  ) dut (
    .mclk(mclk), .reset(reset), .ev_strobe(ev_strobe),
    .ram_write_sync(ram_write_sync), .ram_addr_sync(ram_addr_sync),
    .ram_read_sync(ram_read_sync), .ram_a_sync(ram_a_sync), .ram_d_sync(ram_d_sync),
    .usb_full(usb_full), .usb_d(usb_d), .usb_slwr_n(usb_slwr_n),
    .usb_pktend_n(usb_pktend_n), .fifo_level(fifo_level),
    .drop_count(drop_count), .overflow_pulse(overflow_pulse)
  );

  // clock / reset block
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // byte/pktend monitor, sampled on the falling edge
  always @(negedge mclk) begin
    if (!reset) begin
      if (usb_slwr_n == 1'b0) begin
        got_q.push_back(usb_d);
        last_wr_cyc = cyc;
      end
      if (usb_pktend_n == 1'b0) begin
        pktend_cnt++;
        last_pkt_cyc = cyc;
      end
      if (overflow_pulse) ovf_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  task automatic send_ev(input logic w, input logic a, input logic r,
                         input logic [22:0] addr, input logic [15:0] data);
    ram_write_sync = w;
    ram_addr_sync  = a;
    ram_read_sync  = r;
    ram_a_sync     = addr;
    ram_d_sync     = data;
    ev_strobe      = 1'b1;
    tick();
    ev_strobe      = 1'b0;
    ram_write_sync = 1'b0;
    ram_addr_sync  = 1'b0;
    ram_read_sync  = 1'b0;
  endtask

  task automatic push_pkt(input logic [31:0] p);
    exp_q.push_back(p[31:24]);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b1;
    for (int c = 0; got_q.size() < n; c++) begin
      if (c >= budget) begin
        ok = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ev_strobe = 1'b0; ram_write_sync = 1'b0; ram_addr_sync = 1'b0;
    ram_read_sync = 1'b0; ram_a_sync = '0; ram_d_sync = '0; usb_full = 1'b0;
    repeat (3) tick();
    checks++;
    if ({usb_d, usb_slwr_n, usb_pktend_n} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_usb: got d=%02h slwr_n=%b pktend_n=%b, expected 00 1 1",
               usb_d, usb_slwr_n, usb_pktend_n);
    end
    checks++;
    if ({fifo_level, drop_count, overflow_pulse} !== {5'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got level=%0d drops=%0d ovf=%b, expected 0 0 0",
               fifo_level, drop_count, overflow_pulse);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    send_ev(1'b0, 1'b1, 1'b0, 23'h12345, 16'h0000);
    checks++;
    if (fifo_level !== 5'd1) begin
      errors++;
      $display("FAIL basic_level: got %0d expected 1", fifo_level);
    end
    send_ev(1'b1, 1'b0, 1'b0, 23'h00000, 16'hBEEF);
    push_pkt(32'h0001_2345);
    push_pkt(32'h4000_BEEF);
    wait_bytes(exp_q.size(), 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_priority();
    bit ok;
    // strobe with no qualifier creates no packet
    send_ev(1'b0, 1'b0, 1'b0, 23'h00055, 16'h0055);
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL prio_none: got level %0d expected 0", fifo_level);
    end
    send_ev(1'b1, 1'b1, 1'b1, 23'h00005, 16'h0022);
    send_ev(1'b0, 1'b1, 1'b1, 23'h00006, 16'h0033);
    push_pkt(32'h4000_0022);
    push_pkt(32'h0000_0006);
    wait_bytes(exp_q.size(), 100, ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL prio_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL prio_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_stall();
    bit ok;
    send_ev(1'b0, 1'b1, 1'b0, 23'h5A6B7C, 16'h0000);
    push_pkt(32'h005A_6B7C);
    wait_bytes(1, 50, ok);
    usb_full = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_first: got %0d bytes expected 1", got_q.size());
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (usb_slwr_n !== 1'b1 || usb_d !== 8'h5A) begin
        errors++;
        $display("FAIL stall_hold%0d: got slwr_n=%b d=%02h expected 1 5a", c, usb_slwr_n, usb_d);
      end
    end
    usb_full = 1'b0;
    wait_bytes(4, 50, ok);
    repeat (10) tick();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d bytes expected 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // One packet is parked in the streamer first so the 16-entry FIFO itself fills.
  task automatic test_overflow();
    bit ok;
    int ovf0;
    usb_full = 1'b1;
    send_ev(1'b1, 1'b0, 1'b0, 23'h0, 16'h0A0A);
    repeat (5) tick();
    ovf0 = ovf_cnt;
    push_pkt(32'h4000_0A0A);
    ram_write_sync = 1'b1;
    ev_strobe = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ram_d_sync = 16'h1000 + 16'(i);
      if (i < 16) push_pkt(32'h4000_1000 + 32'(i));
      tick();
    end
    ev_strobe = 1'b0;
    ram_write_sync = 1'b0;
    tick();
    checks++;
    if (ovf_cnt - ovf0 != 4) begin
      errors++;
      $display("FAIL ovf_pulses: got %0d expected 4", ovf_cnt - ovf0);
    end
    checks++;
    if (drop_count !== 16'd4 || fifo_level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_state: got drops=%0d level=%0d expected 4 16", drop_count, fifo_level);
    end
    push_pkt(32'hC000_0004);
    usb_full = 1'b0;
    wait_bytes(exp_q.size(), 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (drop_count !== 16'd0 || fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL ovf_after: got drops=%0d level=%0d expected 0 0", drop_count, fifo_level);
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Strobe every cycle until the marker enqueue collides with an event.
  task automatic test_marker_race();
    bit ok;
    bit hit;
    int n;
    int ovf0;
    logic [15:0] prev_dc;
    usb_full = 1'b1;
    send_ev(1'b1, 1'b0, 1'b0, 23'h0, 16'h0B0B);
    repeat (5) tick();
    push_pkt(32'h4000_0B0B);
    ram_write_sync = 1'b1;
    ev_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ram_d_sync = 16'h2000 + 16'(i);
      push_pkt(32'h4000_2000 + 32'(i));
      tick();
    end
    ovf0 = ovf_cnt;
    ram_d_sync = 16'h3000;
    n = 0; hit = 1'b0; prev_dc = 16'd0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (c == 3) usb_full = 1'b0;
      tick();
      n++;
      if (drop_count == 16'd1 && prev_dc > 16'd1) hit = 1'b1;
      prev_dc = drop_count;
    end
    ev_strobe = 1'b0;
    ram_write_sync = 1'b0;
    checks++;
    if (!hit || drop_count !== 16'd1) begin
      errors++;
      $display("FAIL race_hit: got hit=%b drops=%0d expected 1 1", hit, drop_count);
    end
    checks++;
    if (ovf_cnt - ovf0 != n) begin
      errors++;
      $display("FAIL race_pulses: got %0d expected %0d", ovf_cnt - ovf0, n);
    end
    push_pkt(32'hC000_0000 | 32'(n - 1));
    push_pkt(32'hC000_0001);
    wait_bytes(exp_q.size(), 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL race_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL race_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL race_after: got drops=%0d expected 0", drop_count);
    end
    got_q.delete(); exp_q.delete();
  endtask

  // pktend falls FLUSH_CYCLES cycles after slwr_n returns high: F+1 cycles after the low sample.
  task automatic test_flush();
    bit ok;
    int pk0;
    repeat (2 * F + 10) tick();
    pk0 = pktend_cnt;
    send_ev(1'b1, 1'b0, 1'b0, 23'h0, 16'h0055);
    wait_bytes(4, 50, ok);
    for (int c = 0; c < 3 * F && pktend_cnt == pk0; c++) tick();
    checks++;
    if (pktend_cnt - pk0 != 1) begin
      errors++;
      $display("FAIL flush_seen: got %0d pulses expected 1", pktend_cnt - pk0);
    end
    checks++;
    if (last_pkt_cyc - last_wr_cyc != F + 1) begin
      errors++;
      $display("FAIL flush_delay: got %0d cycles expected %0d", last_pkt_cyc - last_wr_cyc, F + 1);
    end
    tick();
    checks++;
    if (usb_pktend_n !== 1'b1) begin
      errors++;
      $display("FAIL flush_width: got pktend_n=%b expected 1", usb_pktend_n);
    end
    repeat (3 * F) tick();
    checks++;
    if (pktend_cnt - pk0 != 1) begin
      errors++;
      $display("FAIL flush_repeat: got %0d pulses expected 1", pktend_cnt - pk0);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int ovf0;
    send_ev(1'b1, 1'b0, 1'b0, 23'h0, 16'h1234);
    wait_bytes(1, 50, ok);
    reset = 1'b1;
    #1;
    checks++;
    if ({usb_d, usb_slwr_n, usb_pktend_n, fifo_level, drop_count, overflow_pulse} !==
        {8'h00, 1'b1, 1'b1, 5'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outs: got d=%02h slwr_n=%b pktend_n=%b level=%0d drops=%0d ovf=%b",
               usb_d, usb_slwr_n, usb_pktend_n, fifo_level, drop_count, overflow_pulse);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    got_q.delete();
    ovf0 = ovf_cnt;
    send_ev(1'b0, 1'b0, 1'b1, 23'h000007, 16'h0000);
`ifdef TRACE_READS_EN
    push_pkt(32'h8000_0007);
`endif
    repeat (20) tick();
    checks++;
    if (got_q.size() != exp_q.size() || ovf_cnt != ovf0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL read_count: got %0d bytes ovf=%0d drops=%0d expected %0d 0 0",
               got_q.size(), ovf_cnt - ovf0, drop_count, exp_q.size());
    end
    send_ev(1'b1, 1'b0, 1'b0, 23'h0, 16'h0C0D);
    push_pkt(32'h4000_0C0D);
    wait_bytes(exp_q.size(), 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_timeout: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_full_stall();
    test_overflow();
    test_marker_race();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
